secuenciador_ciclo: RTL

//  Machine-side responder to the Lavanderia payment controller. Consumes its one-cycle mode

---
 rtl/secuenciador_ciclo_pkg.sv | 47 ++++
 rtl/secuenciador_ciclo_if.sv | 26 ++
 rtl/secuenciador_ciclo_temporizador.sv | 41 ++++
 rtl/secuenciador_ciclo.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/secuenciador_ciclo_pkg.sv
// Shared definitions for the laundry cycle sequencer: phase codes, actuator bundle
// and the phase-to-actuator decode used by the output stage.
package secuenciador_ciclo_pkg;

  localparam int FASE_W = 3;

  typedef enum logic [FASE_W-1:0] {
    FASE_REPOSO   = 3'd0,
    FASE_LLENADO  = 3'd1,
    FASE_LAVADO   = 3'd2,
    FASE_ENJUAGUE = 3'd3,
    FASE_CENTRIF  = 3'd4,
    FASE_SECADO   = 3'd5,
    FASE_FIN      = 3'd6
  } fase_e;

  typedef struct packed {
    logic valvula;
    logic motor;
    logic centrifugar;
    logic calentar;
  } actuadores_t;

  function automatic actuadores_t decodifica_actuadores(input fase_e f);
    actuadores_t a;
    a = '{valvula: 1'b0, motor: 1'b0, centrifugar: 1'b0, calentar: 1'b0};
    case (f)
      FASE_LLENADO:  a.valvula = 1'b1;
      FASE_LAVADO:   a.motor = 1'b1;
      FASE_ENJUAGUE: begin
        a.valvula = 1'b1;
        a.motor   = 1'b1;
      end
      FASE_CENTRIF: begin
        a.motor       = 1'b1;
        a.centrifugar = 1'b1;
      end
      FASE_SECADO: begin
        a.motor    = 1'b1;
        a.calentar = 1'b1;
      end
      default: a = '{valvula: 1'b0, motor: 1'b0, centrifugar: 1'b0, calentar: 1'b0};
    endcase
    return a;
  endfunction

endpackage

// File: rtl/secuenciador_ciclo_if.sv
// Request/status bundle between the payment controller (master) and the machine
// sequencer (slave).
interface secuenciador_ciclo_if;
  logic       LAVADO;
  logic       LAVADO_PESADO;
  logic       SECADO;
  logic       insuficiente;
  logic       ocupado;
  logic [2:0] fase;
  logic       valvula;
  logic       motor;
  logic       centrifugar;
  logic       calentar;
  logic       terminado;
  logic       rechazo;

  modport master (
    output LAVADO, LAVADO_PESADO, SECADO, insuficiente,
    input  ocupado, fase, valvula, motor, centrifugar, calentar, terminado, rechazo
  );

  modport slave (
    input  LAVADO, LAVADO_PESADO, SECADO, insuficiente,
    output ocupado, fase, valvula, motor, centrifugar, calentar, terminado, rechazo
  );
endinterface

// File: rtl/secuenciador_ciclo_temporizador.sv
// Phase timer: CW-bit down counter that loads on request, holds at zero and flags
// expiry while the count is zero.
module temporizador_fase #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          carga_i,
  input  logic [CW-1:0] valor_i,
  output logic [CW-1:0] cuenta_o,
  output logic          expira_o
);

  logic [CW-1:0] cuenta_d;
  logic [CW-1:0] cuenta_q;

  // Next count: load wins, otherwise count down and saturate at zero.
  always_comb begin
    cuenta_d = cuenta_q;
    if (carga_i) begin
      cuenta_d = valor_i;
    end else if (cuenta_q != {CW{1'b0}}) begin
      cuenta_d = cuenta_q - CW'(1);
    end else begin
      cuenta_d = cuenta_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cuenta_q <= {CW{1'b0}};
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

  assign cuenta_o = cuenta_q;
  assign expira_o = (cuenta_q == {CW{1'b0}});

endmodule

// File: rtl/secuenciador_ciclo.sv
// Timed laundry cycle sequencer: accepts one-cycle mode requests from the payment
// controller and steps fill/wash/rinse/spin/dry, driving registered actuator enables.
module secuenciador_ciclo
  import secuenciador_ciclo_pkg::*;
#(
  parameter int CW         = 8,
  parameter int T_LLENADO  = 4,
  parameter int T_LAVADO   = 8,
  parameter int T_EXTRA    = 4,
  parameter int T_ENJUAGUE = 4,
  parameter int T_CENTRIF  = 4,
  parameter int T_SECADO   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  secuenciador_ciclo_if.slave  bus
);

  localparam logic [CW-1:0] C_LLENADO  = CW'(T_LLENADO - 1);
  localparam logic [CW-1:0] C_LAVADO   = CW'(T_LAVADO - 1);
  localparam logic [CW-1:0] C_PESADO   = CW'(T_LAVADO + T_EXTRA - 1);
  localparam logic [CW-1:0] C_ENJUAGUE = CW'(T_ENJUAGUE - 1);
  localparam logic [CW-1:0] C_CENTRIF  = CW'(T_CENTRIF - 1);
  localparam logic [CW-1:0] C_SECADO   = CW'(T_SECADO - 1);

  fase_e         state_d, state_q;
  logic          pesado_d, pesado_q;
  logic          segundo_d, segundo_q;
  logic          carga_s;
  logic [CW-1:0] valor_carga_s;
  logic [CW-1:0] cuenta_unused_s;
  logic          expira_s;
  logic          hay_pedido_s;
  logic          libre_s;
  logic          acepta_s;

  logic          ocupado_d, ocupado_q;
  logic [2:0]    fase_d, fase_q;
  actuadores_t   act_d, act_q;
  logic          terminado_d, terminado_q;
  logic          rechazo_d, rechazo_q;

  temporizador_fase #(.CW(CW)) u_temporizador (
    .clk      (clk),
    .rst      (rst),
    .carga_i  (carga_s),
    .valor_i  (valor_carga_s),
    .cuenta_o (cuenta_unused_s),
    .expira_o (expira_s)
  );

  // Idle means idle as seen from outside too, so the FIN cycle still rejects.
  assign hay_pedido_s = bus.LAVADO | bus.LAVADO_PESADO | bus.SECADO;
  assign libre_s      = (state_q == FASE_REPOSO) && !ocupado_q;
  assign acepta_s     = libre_s && !bus.insuficiente;

  // Next-state, flag and timer-load logic.
  always_comb begin
    state_d       = state_q;
    pesado_d      = pesado_q;
    segundo_d     = segundo_q;
    carga_s       = 1'b0;
    valor_carga_s = {CW{1'b0}};
    case (state_q)
      FASE_REPOSO: begin
        if (acepta_s && bus.LAVADO_PESADO) begin
          state_d = FASE_LLENADO; pesado_d = 1'b1; segundo_d = 1'b0;
          carga_s = 1'b1; valor_carga_s = C_LLENADO;
        end else if (acepta_s && bus.LAVADO) begin
          state_d = FASE_LLENADO; pesado_d = 1'b0; segundo_d = 1'b0;
          carga_s = 1'b1; valor_carga_s = C_LLENADO;
        end else if (acepta_s && bus.SECADO) begin
          state_d = FASE_SECADO; pesado_d = 1'b0; segundo_d = 1'b0;
          carga_s = 1'b1; valor_carga_s = C_SECADO;
        end else begin
          state_d = FASE_REPOSO;
        end
      end
      FASE_LLENADO: begin
        if (expira_s) begin
          state_d = FASE_LAVADO; carga_s = 1'b1;
          valor_carga_s = pesado_q ? C_PESADO : C_LAVADO;
        end else begin
          state_d = FASE_LLENADO;
        end
      end
      FASE_LAVADO: begin
        if (expira_s) begin
          state_d = FASE_ENJUAGUE; carga_s = 1'b1; valor_carga_s = C_ENJUAGUE;
        end else begin
          state_d = FASE_LAVADO;
        end
      end
      FASE_ENJUAGUE: begin
        // Heavy wash repeats the rinse once, with no gap between passes.
        if (expira_s && pesado_q && !segundo_q) begin
          segundo_d = 1'b1; carga_s = 1'b1; valor_carga_s = C_ENJUAGUE;
        end else if (expira_s) begin
          state_d = FASE_CENTRIF; carga_s = 1'b1; valor_carga_s = C_CENTRIF;
        end else begin
          state_d = FASE_ENJUAGUE;
        end
      end
      FASE_CENTRIF: begin
        if (expira_s) begin
          state_d = FASE_FIN;
        end else begin
          state_d = FASE_CENTRIF;
        end
      end
      FASE_SECADO: begin
        if (expira_s) begin
          state_d = FASE_FIN;
        end else begin
          state_d = FASE_SECADO;
        end
      end
      FASE_FIN: begin
        state_d = FASE_REPOSO; pesado_d = 1'b0; segundo_d = 1'b0;
      end
      default: begin
        state_d = FASE_REPOSO; pesado_d = 1'b0; segundo_d = 1'b0;
      end
    endcase
  end

  // State and mode flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FASE_REPOSO;
      pesado_q  <= 1'b0;
      segundo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pesado_q  <= pesado_d;
      segundo_q <= segundo_d;
    end
  end

  // Moore decode of the current state, registered one cycle behind it.
  always_comb begin
    fase_d      = 3'(state_q);
    ocupado_d   = (state_q != FASE_REPOSO);
    act_d       = decodifica_actuadores(state_q);
    terminado_d = (state_q == FASE_FIN);
    rechazo_d   = hay_pedido_s && !acepta_s;
  end

  // Output registers; reset drops every actuator immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fase_q      <= 3'd0;
      ocupado_q   <= 1'b0;
      act_q       <= '{valvula: 1'b0, motor: 1'b0, centrifugar: 1'b0, calentar: 1'b0};
      terminado_q <= 1'b0;
      rechazo_q   <= 1'b0;
    end else begin
      fase_q      <= fase_d;
      ocupado_q   <= ocupado_d;
      act_q       <= act_d;
      terminado_q <= terminado_d;
      rechazo_q   <= rechazo_d;
    end
  end

  assign bus.fase        = fase_q;
  assign bus.ocupado     = ocupado_q;
  assign bus.valvula     = act_q.valvula;
  assign bus.motor       = act_q.motor;
  assign bus.centrifugar = act_q.centrifugar;
  assign bus.calentar    = act_q.calentar;
  assign bus.terminado   = terminado_q;
  assign bus.rechazo     = rechazo_q;

endmodule
